// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer commit controller: in-order allocate, out-of-order complete, in-order retire.
// Optional commit counter output enabled by defining ROB_COMMIT_CNT_EN.
module rob_commit_ctrl #(
    parameter int unsigned ROB_POS_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     issue,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_is_branch,
    input  logic                     issue_ready,
    input  logic [DATA_WIDTH-1:0]    issue_val,
    output logic [ROB_POS_WIDTH-1:0] issue_rob_pos,
    output logic                     rob_full,
    input  logic                     res_valid,
    input  logic [ROB_POS_WIDTH-1:0] res_rob_pos,
    input  logic [DATA_WIDTH-1:0]    res_val,
    input  logic                     res_mispredict,
    input  logic [DATA_WIDTH-1:0]    res_target_pc,
    input  logic [ROB_POS_WIDTH-1:0] query_pos1,
    input  logic [ROB_POS_WIDTH-1:0] query_pos2,
    output logic                     query_ready1,
    output logic                     query_ready2,
    output logic [DATA_WIDTH-1:0]    query_val1,
    output logic [DATA_WIDTH-1:0]    query_val2,
    output logic                     rob_commit,
    output logic [4:0]               rob_commit_rd,
    output logic [DATA_WIDTH-1:0]    rob_commit_val,
    output logic [ROB_POS_WIDTH-1:0] rob_commit_rob_pos,
    output logic                     rollback,
    output logic [DATA_WIDTH-1:0]    rollback_pc
`ifdef ROB_COMMIT_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0]    commit_count
`endif
);

    localparam int unsigned ROB_SIZE = 1 << ROB_POS_WIDTH;
    localparam int unsigned CNT_W    = ROB_POS_WIDTH + 1;

    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] val;
        logic                  is_branch;
        logic                  mispredict;
        logic [DATA_WIDTH-1:0] target_pc;
    } rob_entry_t;

    rob_entry_t               entries [ROB_SIZE];
    logic [ROB_POS_WIDTH-1:0] head;
    logic [ROB_POS_WIDTH-1:0] tail;
    logic [CNT_W-1:0]         count;

    rob_entry_t head_entry;
    logic       head_done;
    logic       do_flush;
    logic       do_commit;
    logic       issue_ok;
    logic       res_hit;

    assign issue_rob_pos = tail;
    assign rob_full      = (count == CNT_W'(ROB_SIZE));

    // Retire decision is taken on the registered head entry only.
    always_comb begin
        head_entry = entries[head];
        head_done  = head_entry.busy && head_entry.ready;
        do_flush   = head_done && head_entry.is_branch && head_entry.mispredict;
        do_commit  = head_done && !do_flush;
        issue_ok   = issue && !rob_full && !rollback;
        res_hit    = res_valid && entries[res_rob_pos].busy;
    end

    // Operand lookup with same-cycle bypass from the result bus.
    always_comb begin
        query_ready1 = entries[query_pos1].ready;
        query_val1   = entries[query_pos1].val;
        query_ready2 = entries[query_pos2].ready;
        query_val2   = entries[query_pos2].val;
        if (res_valid && (res_rob_pos == query_pos1)) begin
            query_ready1 = 1'b1;
            query_val1   = res_val;
        end
        if (res_valid && (res_rob_pos == query_pos2)) begin
            query_ready2 = 1'b1;
            query_val2   = res_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            rob_commit         <= 1'b0;
            rob_commit_rd      <= '0;
            rob_commit_val     <= '0;
            rob_commit_rob_pos <= '0;
            rollback           <= 1'b0;
            rollback_pc        <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (!rdy) begin
            rob_commit <= 1'b0;
            rollback   <= 1'b0;
        end else begin
            rob_commit <= 1'b0;
            rollback   <= 1'b0;
            if (do_flush) begin
                // Mispredicted branch reached head: drop everything, inputs this edge included.
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                rollback    <= 1'b1;
                rollback_pc <= head_entry.target_pc;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries[i] <= '0;
                end
            end else begin
                if (res_hit) begin
                    entries[res_rob_pos].ready      <= 1'b1;
                    entries[res_rob_pos].val        <= res_val;
                    entries[res_rob_pos].mispredict <= res_mispredict;
                    entries[res_rob_pos].target_pc  <= res_target_pc;
                end
                if (issue_ok) begin
                    entries[tail] <= '{busy: 1'b1, ready: issue_ready, rd: issue_rd,
                                       val: issue_val, is_branch: issue_is_branch,
                                       mispredict: 1'b0, target_pc: '0};
                    tail <= tail + ROB_POS_WIDTH'(1);
                end
                if (do_commit) begin
                    entries[head].busy  <= 1'b0;
                    entries[head].ready <= 1'b0;
                    head                <= head + ROB_POS_WIDTH'(1);
                    rob_commit          <= 1'b1;
                    rob_commit_rd       <= head_entry.rd;
                    rob_commit_val      <= head_entry.val;
                    rob_commit_rob_pos  <= head;
                end
                count <= count + CNT_W'(issue_ok) - CNT_W'(do_commit);
            end
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_count <= '0;
        end else if (rdy && do_commit) begin
            commit_count <= commit_count + DATA_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder-buffer controller that sequences every write into the register file's commit port.
- Allocates in-order entries at decode, collects out-of-order results, retires them strictly in program order onto RegFile's commit interface, and broadcasts rollback on branch mispredict.
- Also answers decoder operand queries for renamed registers, so RegFile's rob_id tags resolve to values.
- Sits between Decoder/issue, execution result bus and RegFile.

Parameters:
- ROB_POS_WIDTH, 4, log2 of entry count (16 entries); rob_pos fields are this wide, rob_id fields are ROB_POS_WIDTH+1 ({renamed flag, pos}).
- DATA_WIDTH, 32, value and pc width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; state frozen when low.
- issue  in  1  allocate entry at tail this cycle.
- issue_rd  in  5  destination register (0 = none).
- issue_is_branch  in  1  entry is a conditional branch.
- issue_ready  in  1  result already known at issue.
- issue_val  in  DATA_WIDTH  result if issue_ready.
- issue_rob_pos  out  ROB_POS_WIDTH  current tail; position the next issue receives (combinational).
- rob_full  out  1  count == 2^ROB_POS_WIDTH (combinational).
- res_valid  in  1  execution result broadcast.
- res_rob_pos  in  ROB_POS_WIDTH  target entry.
- res_val  in  DATA_WIDTH  result value.
- res_mispredict  in  1  branch outcome differs from prediction.
- res_target_pc  in  DATA_WIDTH  correct pc for a mispredicted branch.
- query_pos1, query_pos2  in  ROB_POS_WIDTH  decoder lookups.
- query_ready1, query_ready2  out  1  entry result available (combinational).
- query_val1, query_val2  out  DATA_WIDTH  entry value (combinational).
- rob_commit  out  1  one-cycle commit pulse to RegFile.
- rob_commit_rd  out  5  committed rd.
- rob_commit_val  out  DATA_WIDTH  committed value.
- rob_commit_rob_pos  out  ROB_POS_WIDTH  committed entry position.
- rollback  out  1  one-cycle flush pulse.
- rollback_pc  out  DATA_WIDTH  refetch pc.

Behaviour:
- Reset: head = tail = count = 0; all entries invalid; rob_commit, rollback = 0; rob_commit_rd, rob_commit_val, rob_commit_rob_pos, rollback_pc = 0.
- rdy low: no state change; rob_commit and rollback drive 0.
- Entry fields: busy, ready, rd, val, is_branch, mispredict, target_pc.
- Issue: accepted only when issue && !rob_full && !rollback.
  - Writes the entry at tail: busy = 1, ready = issue_ready, val = issue_val, mispredict = 0.
  - tail wraps mod 2^ROB_POS_WIDTH.
  - If issue is asserted while full, it is ignored; the decoder must stall.
- Result: when res_valid and entry busy, set ready = 1 and store val, mispredict and target_pc at clk edge. A result for a non-busy entry is ignored.
- Commit, registered and evaluated on the state at the clk edge, at most one per cycle:
  - Condition: head entry busy && ready.
  - If not (is_branch && mispredict): rob_commit = 1 next cycle with the entry's rd/val/pos; entry freed; head++.
  - rd = 0 entries still pulse rob_commit (RegFile discards them).
  - Branch entries without mispredict commit with rob_commit = 1.
- Mispredict at head: rollback = 1 and rollback_pc = target_pc next cycle; rob_commit = 0; every entry cleared; head = tail = count = 0. Issue and result inputs in that same edge are discarded.
- Latency: an entry issued ready at edge t commits at edge t+1 (pulse visible cycle t+1). A result arriving at edge t makes a head entry commit at edge t+1.
- Simultaneous issue and commit: count unchanged; full/empty computed from the registered count.
  - A full ROB that commits this cycle still reports full and rejects the issue.
- Query bypass: if res_valid targets the queried pos in the current cycle, query_ready = 1 and query_val = res_val. Otherwise return the stored entry.
- Pulses (rob_commit, rollback) are one cycle wide; other outputs hold their last value.
- Reset mid-operation discards all entries; no commit or rollback is emitted.

Optional Feature:
- ROB_COMMIT_CNT_EN: when defined, adds output commit_count [DATA_WIDTH].
  - Reset 0; increments by 1 for each rob_commit pulse; not incremented on rollback; wraps at 2^32.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Issue rd=5, ready, val=0x1234 at cycle 1 → cycle 2: rob_commit=1, rd=5, val=0x1234, pos=0.
- Issue A (rd=1), B (rd=2) not ready; result B=7 then A=3 → commits A (val 3) then B (val 7) in order, on consecutive cycles after A's result.
- Issue 16 entries with no results → rob_full=1 and a 17th issue is ignored. Results for pos 0 → commit, then rob_full=0 and the next issue gets pos 0.
- Branch at pos 2 with res_mispredict=1, target 0x80 (entries 3-5 pending) → after 0-1 commit, rollback=1 with rollback_pc=0x80, no commit of 2-5, issue_rob_pos=0.
- query_pos1=3 while res_valid on pos 3 with val 0xAA → query_ready1=1, query_val1=0xAA in the same cycle.
- rst asserted with 4 busy entries → next cycle count=0, rob_commit=0, rollback=0, rob_full=0.
